// File: rtl/md_pkg.sv
// md_pkg: shared MD opcode/state encodings and default width for md_unit.
package md_pkg;
  localparam int MD_WIDTH = 32;
  typedef enum logic [2:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_RSVD
  } md_op_e;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_e;
endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle for md_unit.
//   master drives Start/Md_op/Operand_a/Operand_b/Flush,
//   slave drives Busy/Done/Hi_data/Lo_data/Divide_zero.
interface md_unit_if import md_pkg::*; #(parameter int DATA_WIDTH = MD_WIDTH);
  logic                  Start;
  logic [2:0]            Md_op;
  logic [DATA_WIDTH-1:0] Operand_a;
  logic [DATA_WIDTH-1:0] Operand_b;
  logic                  Flush;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] Hi_data;
  logic [DATA_WIDTH-1:0] Lo_data;
  logic                  Divide_zero;
  modport master (output Start, Md_op, Operand_a, Operand_b, Flush,
                  input  Busy, Done, Hi_data, Lo_data, Divide_zero);
  modport slave  (input  Start, Md_op, Operand_a, Operand_b, Flush,
                  output Busy, Done, Hi_data, Lo_data, Divide_zero);
endinterface

// File: rtl/md_div_core.sv
// md_div_core: iterative unsigned restoring divider, one quotient bit per step.
//   start loads dividend/divisor, step performs one shift-subtract,
//   last flags the step that produces the final quotient bit.
module md_div_core import md_pkg::*; #(
  parameter int W = MD_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         last,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  localparam int CW = $clog2(W);
  logic [CW-1:0] cnt;
  logic [W-1:0]  d;
  logic [W:0]    trial;
  // Partial remainder stays below the divisor, so W+1 bits hold the signed difference.
  assign trial = {remainder, quotient[W-1]} - {1'b0, d};
  assign last  = cnt == CW'(W - 1);
  always_ff @(posedge clock)
    if (reset) begin
      cnt       <= '0;
      d         <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      cnt       <= '0;
      d         <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (step) begin
      cnt       <= cnt + 1'b1;
      quotient  <= {quotient[W-2:0], ~trial[W]};
      remainder <= trial[W] ? {remainder[W-2:0], quotient[W-1]} : trial[W-1:0];
    end
endmodule

// File: rtl/md_unit.sv
// md_unit: multiply/divide execute unit with private HI/LO registers.
//   clock/reset: system clock, synchronous active-high reset.
//   bus (slave): Start/Md_op/Operand_a/Operand_b/Flush in; Busy/Done/Hi_data/Lo_data/Divide_zero out.
//   MD_UNIT_DIV_ZERO_TRAP_EN: when defined, a zero divisor pulses Divide_zero instead of dividing.
module md_unit import md_pkg::*; #(
  parameter int                    DATA_WIDTH = MD_WIDTH,
  parameter logic [DATA_WIDTH-1:0] HILO_RESET = '0
) (
  input  logic       clock,
  input  logic       reset,
  md_unit_if.slave   bus
);
  localparam int W = DATA_WIDTH;
  md_state_e      state, state_n;
  md_op_e         op;
  logic           accept, is_mul, is_div, signed_op, div_trap, div_start, last;
  logic           sgn, q_neg, r_neg;
  logic [W-1:0]   a_q, b_q, hi, lo, quo, rem, mag_a, mag_b;
  logic [2*W-1:0] ax, bx, prod;
  assign op        = md_op_e'(bus.Md_op);
  assign is_mul    = op == MD_MULT || op == MD_MULTU;
  assign is_div    = op == MD_DIV || op == MD_DIVU;
  assign signed_op = op == MD_MULT || op == MD_DIV;
  assign bus.Busy  = state != IDLE;
  assign accept    = bus.Start && !bus.Busy && !bus.Flush;
  assign div_start = accept && is_div && !div_trap;
  assign bus.Done  = (state == MUL || state == FIX) && !bus.Flush;
  assign bus.Hi_data = hi;
  assign bus.Lo_data = lo;
  assign mag_a = signed_op && bus.Operand_a[W-1] ? -bus.Operand_a : bus.Operand_a;
  assign mag_b = signed_op && bus.Operand_b[W-1] ? -bus.Operand_b : bus.Operand_b;
  // Extending both operands to 2W bits lets one unsigned multiplier serve mult and multu.
  assign ax   = {{W{sgn && a_q[W-1]}}, a_q};
  assign bx   = {{W{sgn && b_q[W-1]}}, b_q};
  assign prod = ax * bx;
`ifdef MD_UNIT_DIV_ZERO_TRAP_EN
  logic dz;
  assign div_trap = is_div && bus.Operand_b == '0;
  assign bus.Divide_zero = dz;
  always_ff @(posedge clock)
    dz <= reset ? 1'b0 : accept && div_trap;
`else
  assign div_trap = 1'b0;
  assign bus.Divide_zero = 1'b0;
`endif
  md_div_core #(.W(W)) u_div (
    .clock(clock),
    .reset(reset),
    .start(div_start),
    .step(state == DIV),
    .dividend(mag_a),
    .divisor(mag_b),
    .last(last),
    .quotient(quo),
    .remainder(rem)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept && is_mul ? MUL : div_start ? DIV : IDLE;
      MUL:     state_n = IDLE;
      DIV:     state_n = last ? FIX : DIV;
      default: state_n = IDLE;
    endcase
    if (bus.Flush) state_n = IDLE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      hi    <= HILO_RESET;
      lo    <= HILO_RESET;
      a_q   <= '0;
      b_q   <= '0;
      sgn   <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_q   <= bus.Operand_a;
        b_q   <= bus.Operand_b;
        sgn   <= signed_op;
        q_neg <= op == MD_DIV && (bus.Operand_a[W-1] ^ bus.Operand_b[W-1]);
        r_neg <= op == MD_DIV && bus.Operand_a[W-1];
      end
      if (accept && op == MD_MTHI) hi <= bus.Operand_a;
      if (accept && op == MD_MTLO) lo <= bus.Operand_a;
      if (bus.Done) {hi, lo} <= state == MUL ? prod : {r_neg ? -rem : rem, q_neg ? -quo : quo};
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
module tb_md_unit;
  import md_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   nb, nd;
  md_unit_if #(.DATA_WIDTH(32)) bus();
  md_unit #(.DATA_WIDTH(32), .HILO_RESET(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.Start = 1'b1;
    bus.Md_op = op;
    bus.Operand_a = a;
    bus.Operand_b = b;
    @(negedge clock);
    bus.Start = 1'b0;
  endtask
  task automatic wait_idle(output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 200 && bus.Busy; i++) begin
      busy_n++;
      done_n += int'(bus.Done);
      @(negedge clock);
    end
  endtask
  initial begin
    bus.Start = 1'b0;
    bus.Md_op = 3'd0;
    bus.Operand_a = '0;
    bus.Operand_b = '0;
    bus.Flush = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_hi", bus.Hi_data, 0);
    chk("rst_lo", bus.Lo_data, 0);
    chk("rst_dz", bus.Divide_zero, 0);
    bus.Start = 1'b1;
    bus.Md_op = MD_MTHI;
    bus.Operand_a = 32'h12345678;
    @(negedge clock);
    chk("mthi_hi", bus.Hi_data, 32'h12345678);
    chk("mthi_busy", bus.Busy, 0);
    bus.Md_op = MD_MTLO;
    bus.Operand_a = 32'hCAFEBABE;
    @(negedge clock);
    bus.Start = 1'b0;
    chk("mtlo_lo", bus.Lo_data, 32'hCAFEBABE);
    chk("mtlo_hi", bus.Hi_data, 32'h12345678);
    chk("mtlo_busy", bus.Busy, 0);
    chk("mtlo_done", bus.Done, 0);
    go(MD_MULT, 32'hFFFFFFFF, 32'd2);
    wait_idle(nb, nd);
    chk("mult_busy_n", nb, 1);
    chk("mult_done_n", nd, 1);
    chk("mult_hi", bus.Hi_data, 32'hFFFFFFFF);
    chk("mult_lo", bus.Lo_data, 32'hFFFFFFFE);
    go(MD_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_idle(nb, nd);
    chk("multu_busy_n", nb, 1);
    chk("multu_hi", bus.Hi_data, 32'h00000001);
    chk("multu_lo", bus.Lo_data, 32'hFFFFFFFE);
    go(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(nb, nd);
    chk("div_busy_n", nb, 33);
    chk("div_done_n", nd, 1);
    chk("div_lo", bus.Lo_data, 32'hFFFFFFFD);
    chk("div_hi", bus.Hi_data, 32'hFFFFFFFF);
    chk("div_done_after", bus.Done, 0);
    go(MD_DIVU, 32'd100, 32'd7);
    wait_idle(nb, nd);
    chk("divu_busy_n", nb, 33);
    chk("divu_lo", bus.Lo_data, 32'd14);
    chk("divu_hi", bus.Hi_data, 32'd2);
    go(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(nb, nd);
    chk("ovf_lo", bus.Lo_data, 32'h80000000);
    chk("ovf_hi", bus.Hi_data, 32'h0);
    chk("ovf_dz", bus.Divide_zero, 0);
    go(MD_DIVU, 32'd1000, 32'd7);
    repeat (4) @(negedge clock);
    bus.Start = 1'b1;
    bus.Md_op = MD_MULT;
    bus.Operand_a = 32'd3;
    bus.Operand_b = 32'd5;
    @(negedge clock);
    bus.Start = 1'b0;
    wait_idle(nb, nd);
    chk("ign_done_n", nd, 1);
    chk("ign_lo", bus.Lo_data, 32'd142);
    chk("ign_hi", bus.Hi_data, 32'd6);
    @(negedge clock);
    chk("ign_busy_after", bus.Busy, 0);
    chk("ign_done_after", bus.Done, 0);
    go(MD_DIV, 32'd100, 32'd3);
    repeat (9) @(negedge clock);
    bus.Flush = 1'b1;
    @(negedge clock);
    bus.Flush = 1'b0;
    chk("flush_busy", bus.Busy, 0);
    chk("flush_done", bus.Done, 0);
    chk("flush_hi", bus.Hi_data, 32'd6);
    chk("flush_lo", bus.Lo_data, 32'd142);
    bus.Start = 1'b1;
    bus.Md_op = MD_MULTU;
    bus.Operand_a = 32'd3;
    bus.Operand_b = 32'd5;
    @(negedge clock);
    bus.Start = 1'b0;
    chk("post_flush_busy", bus.Busy, 1);
    wait_idle(nb, nd);
    chk("post_flush_hi", bus.Hi_data, 32'd0);
    chk("post_flush_lo", bus.Lo_data, 32'd15);
    bus.Start = 1'b1;
    bus.Flush = 1'b1;
    bus.Md_op = MD_MTLO;
    bus.Operand_a = 32'hDEAD;
    @(negedge clock);
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    chk("flush_drop_lo", bus.Lo_data, 32'd15);
    chk("flush_drop_busy", bus.Busy, 0);
`ifdef MD_UNIT_DIV_ZERO_TRAP_EN
    go(MD_DIVU, 32'd5, 32'd0);
    chk("dz_pulse", bus.Divide_zero, 1);
    chk("dz_busy", bus.Busy, 0);
    chk("dz_done", bus.Done, 0);
    @(negedge clock);
    chk("dz_pulse_end", bus.Divide_zero, 0);
    chk("dz_hi", bus.Hi_data, 32'd0);
    chk("dz_lo", bus.Lo_data, 32'd15);
`else
    go(MD_DIVU, 32'd5, 32'd0);
    chk("dz_flag", bus.Divide_zero, 0);
    wait_idle(nb, nd);
    chk("dz_busy_n", nb, 33);
    chk("dz_lo", bus.Lo_data, 32'hFFFFFFFF);
    chk("dz_hi", bus.Hi_data, 32'd5);
`endif
    go(MD_DIVU, 32'd50, 32'd3);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_busy", bus.Busy, 0);
    chk("mid_rst_done", bus.Done, 0);
    chk("mid_rst_hi", bus.Hi_data, 0);
    chk("mid_rst_lo", bus.Lo_data, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide execute-stage unit of the Minisys-1A pipeline; sits directly downstream of instruction decode.
- Consumes decoded rs/rt operands (forwarded values) and an MD opcode.
- Executes mult/multu/div/divu/mthi/mtlo against private HI/LO registers.
- Drives Busy so upstream stalls, and exposes HI/LO for mfhi/mflo write-back.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width (iteration count of divider = DATA_WIDTH)
HILO_RESET, 32'h00000000, reset value of HI and LO

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
Start  input  1  request valid this cycle; accepted only when Busy=0
Md_op  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none)
Operand_a  input  DATA_WIDTH  rs value (dividend / multiplicand / mthi-mtlo source)
Operand_b  input  DATA_WIDTH  rt value (divisor / multiplier)
Flush  input  1  exception/eret flush; aborts in-flight operation
Busy  output  1  operation in flight; upstream must hold the next MD instruction
Done  output  1  one-cycle pulse on the cycle HI/LO receive a mult/div result
Hi_data  output  DATA_WIDTH  current HI register
Lo_data  output  DATA_WIDTH  current LO register
Divide_zero  output  1  one-cycle pulse, divisor zero (see Optional Feature)

Behaviour:
- Reset (clock edge with reset=1): state IDLE, HI=LO=HILO_RESET, Busy=0, Done=0, Divide_zero=0, iteration counter 0. Reset mid-operation aborts unconditionally.
- Accept: Start=1 & Busy=0 & Flush=0 at edge T. Start while Busy=1 is ignored, with no queuing.
- mthi/mtlo: HI or LO ← Operand_a at edge T. No Busy, no Done.
- mult/multu: operands latched at T; state MUL. Busy=1 during cycle T..T+1. At edge T+1, {HI,LO} ← 64-bit product (signed for mult, unsigned for multu); Done=1 during that cycle; return to IDLE.
- div/divu: at T, latch operand magnitudes (abs for div, raw for divu), record quotient sign = a[31]^b[31] and remainder sign = a[31] (div only); state DIV, counter=0.
- DIV: one restoring shift-subtract step per cycle for DATA_WIDTH cycles. Counter increments 0..31.
- FIX: one cycle. Apply signs (two's complement negate where recorded). LO ← quotient, HI ← remainder, Done pulse.
- Total Busy = 33 cycles after accept for divide.
- Signed results truncate toward zero; remainder takes the dividend's sign.
- 0x80000000 div 0xFFFFFFFF → LO=0x80000000, HI=0 (wrap, no flag).
- Flush: any state → IDLE at the next edge. HI/LO unchanged, no Done. Flush in IDLE drops a simultaneous Start.
- Busy is combinational from state (state != IDLE).
- Hi_data/Lo_data are pure register outputs; result visible the cycle after Done.

Optional Feature:
- Macro MD_UNIT_DIV_ZERO_TRAP_EN.
- Defined: div/divu with Operand_b=0 does not enter DIV. Divide_zero pulses during cycle T+1, HI/LO unchanged, Busy stays 0, no Done.
- Undefined: Divide_zero is tied 0. Divide-by-zero runs the normal 33-cycle sequence, giving the natural restoring result: divu → LO=0xFFFFFFFF, HI=dividend. div → sign fixup applied to that.

Decomposition:
- Shared package md_pkg holds: Md_op encodings (MD_NONE..MD_MTLO), state encodings (IDLE, MUL, DIV, FIX), DATA_WIDTH default.
- One sub-module, md_div_core, holds the iterative restoring divider datapath: remainder/quotient shift registers and counter, start/step/last handshake.
- md_unit keeps the FSM, multiplier, sign handling and HI/LO.

Test Plan:
- Reset, then mthi 0x12345678 and mtlo 0xCAFEBABE on consecutive cycles → Hi_data=0x12345678, Lo_data=0xCAFEBABE, Busy never high.
- mult 0xFFFFFFFF×2 → Busy 1 cycle, Done, HI=0xFFFFFFFF, LO=0xFFFFFFFE. Then multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div -7/2 → Busy exactly 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 → LO=14, HI=2.
- Start for mult asserted during an in-flight div → ignored. Div result intact, no second Done.
- Flush at cycle 10 of a div → IDLE next edge, HI/LO keep prior values, no Done. New Start accepted the following cycle.
- divu 5/0 → with macro: Divide_zero pulse, HI/LO unchanged, no Busy. Without macro: 33 cycles, LO=0xFFFFFFFF, HI=5.
